des_core_arbiter: RTL and testbench

- Shares one DES control/datapath core between NUM_REQ requesters. Each requester submits a 64-bit block, a 64-bit key and a direction.
- Round-robin arbitration picks one requester. The block then sequences the core's start/ready/done handshake and returns the result tagged with the requester ID.
- Recovers the core after a core error or timeout by pulsing a core reset.
- Sits between the host-side request ports and the DES core (control unit plus datapath).

---
 rtl/des_core_arbiter.sv | 245 ++++++++++++++++++++++++
 tb/tb_des_core_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_core_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : des_core_arbiter
//  Description : Round-robin arbiter sharing one DES core between NUM_REQ
//                requesters. Sequences the core start/ready/done handshake,
//                returns the result tagged with the requester ID and pulses
//                a core reset after a core error or a timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module des_core_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst,

    // host-side request ports
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [64*NUM_REQ-1:0]   req_data,
    input  logic [64*NUM_REQ-1:0]   req_key,
    input  logic [NUM_REQ-1:0]      req_decrypt,

    // DES core side
    output logic                    core_rst,
    output logic                    core_start,
    output logic                    core_data_ready,
    output logic                    core_key_ready,
    output logic [63:0]             core_data_in,
    output logic [63:0]             core_key_in,
    output logic                    core_decrypt,
    input  logic                    core_done,
    input  logic                    core_error,
    input  logic [63:0]             core_data_out,

    // response port
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [63:0]             rsp_data,
    output logic [1:0]              rsp_status,

    output logic                    busy
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [7:0]    c_timeout = 8'(TIMEOUT);
    localparam logic [1:0]    c_st_ok   = 2'b00;
    localparam logic [1:0]    c_st_err  = 2'b01;
    localparam logic [1:0]    c_st_tmo  = 2'b10;
    // one extra bit so pointer+offset can exceed NUM_REQ-1 before wrapping
    localparam logic [ID_W:0] c_num_req = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] c_ptr_rst = ID_W'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_RUN     = 3'd2,
        ST_RELEASE = 3'd3,
        ST_RESPOND = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t             r_state;
    logic [ID_W-1:0]    r_ptr;          // last granted requester
    logic [7:0]         r_timer;        // RUN cycle counter
    logic [63:0]        r_data;         // captured block
    logic [63:0]        r_key;          // captured key
    logic               r_decrypt;      // captured direction
    logic [ID_W-1:0]    r_id;           // captured requester ID
    logic [1:0]         r_status;       // job completion status
    logic [63:0]        r_result;       // captured core result (0 on failure)
    logic               r_core_start;
    logic               r_core_rdy;     // shared data/key qualifier
    logic               r_core_rst_pulse;
    logic               r_rsp_valid;
    logic               r_busy;

    // ------------------------------------------------------------------------
    // Arbitration wires
    // ------------------------------------------------------------------------
    logic               w_grant_valid;
    logic [ID_W-1:0]    w_grant_id;
    logic [ID_W:0]      w_idx;
    logic [63:0]        w_sel_data;
    logic [63:0]        w_sel_key;
    logic               w_sel_decrypt;

    // Round-robin search: first requesting index strictly after the pointer,
    // wrapping around, so the last winner has the lowest priority next time.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_id    = '0;
        w_idx         = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = {1'b0, r_ptr} + (ID_W+1)'(k);
            if (w_idx >= c_num_req) begin
                w_idx = w_idx - c_num_req;
            end
            if (!w_grant_valid && req_valid[w_idx[ID_W-1:0]]) begin
                w_grant_valid = 1'b1;
                w_grant_id    = w_idx[ID_W-1:0];
            end
        end
    end

    // Select the winning requester's block, key and direction for capture.
    always_comb begin
        w_sel_data    = '0;
        w_sel_key     = '0;
        w_sel_decrypt = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant_id == ID_W'(i)) begin
                w_sel_data    = req_data[64*i +: 64];
                w_sel_key     = req_key[64*i +: 64];
                w_sel_decrypt = req_decrypt[i];
            end
        end
    end

    // Accept is combinational in the IDLE cycle so the requester sees it on
    // the same edge that captures its operands.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = !rst && (r_state == ST_IDLE) && w_grant_valid
                                   && (w_grant_id == ID_W'(gi));
        end
    endgenerate

    // Main job sequencer: grant, load, run with timeout, release, respond.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= ST_IDLE;
            r_ptr            <= c_ptr_rst;
            r_timer          <= '0;
            r_data           <= '0;
            r_key            <= '0;
            r_decrypt        <= 1'b0;
            r_id             <= '0;
            r_status         <= c_st_ok;
            r_result         <= '0;
            r_core_start     <= 1'b0;
            r_core_rdy       <= 1'b0;
            r_core_rst_pulse <= 1'b0;
            r_rsp_valid      <= 1'b0;
            r_busy           <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_valid) begin
                        r_data     <= w_sel_data;
                        r_key      <= w_sel_key;
                        r_decrypt  <= w_sel_decrypt;
                        r_id       <= w_grant_id;
                        r_ptr      <= w_grant_id;
                        r_core_rdy <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    r_timer      <= '0;
                    r_core_start <= 1'b1;
                    r_state      <= ST_RUN;
                end

                ST_RUN: begin
                    r_timer <= r_timer + 8'd1;
                    // error wins over done; done wins over timeout
                    if (core_error) begin
                        r_status         <= c_st_err;
                        r_result         <= '0;
                        r_core_start     <= 1'b0;
                        r_core_rdy       <= 1'b0;
                        r_core_rst_pulse <= 1'b1;
                        r_state          <= ST_RELEASE;
                    end else if (core_done) begin
                        r_status     <= c_st_ok;
                        r_result     <= core_data_out;
                        r_core_start <= 1'b0;
                        r_core_rdy   <= 1'b0;
                        r_state      <= ST_RELEASE;
                    end else if (r_timer == c_timeout) begin
                        r_status         <= c_st_tmo;
                        r_result         <= '0;
                        r_core_start     <= 1'b0;
                        r_core_rdy       <= 1'b0;
                        r_core_rst_pulse <= 1'b1;
                        r_state          <= ST_RELEASE;
                    end
                end

                ST_RELEASE: begin
                    // a failed job already reset the core this cycle; a good
                    // job waits for the core to drop done after start falls
                    if (r_status != c_st_ok) begin
                        r_core_rst_pulse <= 1'b0;
                        r_rsp_valid      <= 1'b1;
                        r_state          <= ST_RESPOND;
                    end else if (!core_done) begin
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESPOND;
                    end
                end

                ST_RESPOND: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign core_rst        = rst | r_core_rst_pulse;
    assign core_start      = r_core_start;
    assign core_data_ready = r_core_rdy;
    assign core_key_ready  = r_core_rdy;
    assign core_data_in    = r_data;
    assign core_key_in     = r_key;
    assign core_decrypt    = r_decrypt;

    assign rsp_valid       = r_rsp_valid;
    assign rsp_id          = r_id;
    assign rsp_data        = r_result;
    assign rsp_status      = r_status;
    assign busy            = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_des_core_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_des_core_arbiter
//  Description : Directed bench for des_core_arbiter with a behavioural DES
//                core stand-in and a response scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_des_core_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int TIMEOUT = 255;

    logic                  clk;
    logic                  rst;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [64*NUM_REQ-1:0] req_data;
    logic [64*NUM_REQ-1:0] req_key;
    logic [NUM_REQ-1:0]    req_decrypt;
    logic                  core_rst;
    logic                  core_start;
    logic                  core_data_ready;
    logic                  core_key_ready;
    logic [63:0]           core_data_in;
    logic [63:0]           core_key_in;
    logic                  core_decrypt;
    logic                  core_done;
    logic                  core_error;
    logic [63:0]           core_data_out;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [63:0]           rsp_data;
    logic [1:0]            rsp_status;
    logic                  busy;

    des_core_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_data        (req_data),
        .req_key         (req_key),
        .req_decrypt     (req_decrypt),
        .core_rst        (core_rst),
        .core_start      (core_start),
        .core_data_ready (core_data_ready),
        .core_key_ready  (core_key_ready),
        .core_data_in    (core_data_in),
        .core_key_in     (core_key_in),
        .core_decrypt    (core_decrypt),
        .core_done       (core_done),
        .core_error      (core_error),
        .core_data_out   (core_data_out),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_id          (rsp_id),
        .rsp_data        (rsp_data),
        .rsp_status      (rsp_status),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Counters and scoreboard
    // ------------------------------------------------------------------------
    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [63:0]     data;
        logic [1:0]      st;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int id, input logic [63:0] d, input logic [1:0] st);
        exp_t e;
        e.id   = ID_W'(id);
        e.data = d;
        e.st   = st;
        sb.push_back(e);
    endtask

    task automatic set_req(input int i, input logic [63:0] d, input logic [63:0] k, input logic dec);
        req_data[64*i +: 64] = d;
        req_key[64*i +: 64]  = k;
        req_decrypt[i]       = dec;
    endtask

    // ------------------------------------------------------------------------
    // Behavioural core: result after m_lat start cycles, optional error, or
    // silence; core_rst clears it.
    // ------------------------------------------------------------------------
    localparam int M_NORMAL = 0;
    localparam int M_ERROR  = 1;
    localparam int M_HANG   = 2;

    int m_mode   = M_NORMAL;
    int m_lat    = 99;
    int m_err_at = 5;
    int m_cnt;

    function automatic logic [63:0] core_fn(input logic [63:0] d, input logic [63:0] k, input logic dec);
        if (d == 64'h0123456789ABCDEF && k == 64'h133457799BBCDFF1 && !dec)
            return 64'h85E813540F0AB405;
        return (d ^ (k << 3)) + {63'd0, dec};
    endfunction

    always @(posedge clk) begin
        if (core_rst) begin
            m_cnt         <= 0;
            core_done     <= 1'b0;
            core_error    <= 1'b0;
            core_data_out <= '0;
        end else if (core_start && core_data_ready && core_key_ready) begin
            m_cnt <= m_cnt + 1;
            if (m_mode == M_NORMAL && m_cnt == m_lat - 1) begin
                core_done     <= 1'b1;
                core_data_out <= core_fn(core_data_in, core_key_in, core_decrypt);
            end
            if (m_mode == M_ERROR && m_cnt == m_err_at - 1)
                core_error <= 1'b1;
        end else if (!core_start) begin
            m_cnt         <= 0;
            core_done     <= 1'b0;
            core_data_out <= '0;
        end
    end

    // ------------------------------------------------------------------------
    // Monitors (sampled on the falling edge)
    // ------------------------------------------------------------------------
    int grants = 0;
    int start_pulses = 0, start_run = 0, last_start_len = 0;
    int crst_pulses = 0, crst_run = 0, last_crst_len = 0;

    always @(negedge clk) begin
        if (req_ready != '0) begin
            grants++;
            check("req_ready_onehot", 64'($onehot(req_ready)), 64'd1);
        end
        if (core_start) begin
            start_run++;
        end else if (start_run != 0) begin
            last_start_len = start_run;
            start_pulses++;
            start_run = 0;
        end
        if (rst) begin
            crst_run = 0;
        end else if (core_rst) begin
            crst_run++;
        end else if (crst_run != 0) begin
            last_crst_len = crst_run;
            crst_pulses++;
            crst_run = 0;
        end
        if (!rst && rsp_valid && rsp_ready) begin
            check("rsp_pending", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("rsp_id",     64'(rsp_id),     64'(mon_e.id));
                check("rsp_data",   rsp_data,        mon_e.data);
                check("rsp_status", 64'(rsp_status), 64'(mon_e.st));
            end
        end
    end

    // Wait until every expected response is consumed and the block is idle.
    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drained"}, 64'(n < 3000), 64'd1);
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    int g0, s0, c0, n;
    logic [63:0] exp_d;

    initial begin
        rst         = 1'b1;
        req_valid   = '0;
        req_data    = '0;
        req_key     = '0;
        req_decrypt = '0;
        rsp_ready   = 1'b1;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",      64'(busy),       64'd0);
        check("rst_req_ready", 64'(req_ready),  64'd0);
        check("rst_rsp_valid", 64'(rsp_valid),  64'd0);
        check("rst_core_rst",  64'(core_rst),   64'd1);
        check("rst_core_start",64'(core_start), 64'd0);
        check("rst_core_rdy",  64'({core_data_ready, core_key_ready}), 64'd0);
        check("rst_rsp_fields",{rsp_data ^ 64'(rsp_id) ^ 64'(rsp_status)}, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // grant and encrypt: requester 2 alone, known DES vector
        g0 = grants; s0 = start_pulses;
        set_req(2, 64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 1'b0);
        push_exp(2, 64'h85E813540F0AB405, 2'b00);
        req_valid = 4'b0100;
        #1;
        check("t1_req_ready", 64'(req_ready), 64'h4);
        @(posedge clk);
        #1;
        req_valid = '0;
        drain("t1");
        check("t1_grants",       64'(grants - g0),       64'd1);
        check("t1_start_pulses", 64'(start_pulses - s0), 64'd1);

        // round-robin fairness from a fresh pointer
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < NUM_REQ; i++)
            set_req(i, 64'hA5A5_0000_0000_1000 + 64'(i), 64'h0F0F_1234_5678_0000 ^ 64'(i * 7), i[0]);
        push_exp(0, core_fn(64'hA5A5_0000_0000_1000, 64'h0F0F_1234_5678_0000, 1'b0), 2'b00);
        push_exp(1, core_fn(64'hA5A5_0000_0000_1001, 64'h0F0F_1234_5678_0007, 1'b1), 2'b00);
        push_exp(2, core_fn(64'hA5A5_0000_0000_1002, 64'h0F0F_1234_5678_000E, 1'b0), 2'b00);
        push_exp(3, core_fn(64'hA5A5_0000_0000_1003, 64'h0F0F_1234_5678_0015, 1'b1), 2'b00);
        push_exp(0, core_fn(64'hA5A5_0000_0000_1000, 64'h0F0F_1234_5678_0000, 1'b0), 2'b00);
        g0 = grants;
        req_valid = 4'b1111;
        n = 0;
        while (grants < g0 + 5 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("t2_five_grants", 64'(grants - g0), 64'd5);
        @(posedge clk);
        #1;
        req_valid = '0;
        drain("t2");

        // core error on requester 1, then a clean job on requester 3
        m_mode = M_ERROR;
        c0 = crst_pulses;
        set_req(1, 64'hDEAD_BEEF_0000_0001, 64'h1111_2222_3333_4444, 1'b0);
        push_exp(1, 64'd0, 2'b01);
        req_valid = 4'b0010;
        #1;
        check("t3_req_ready", 64'(req_ready), 64'h2);
        @(posedge clk);
        #1;
        req_valid = '0;
        drain("t3");
        check("t3_crst_pulses", 64'(crst_pulses - c0), 64'd1);
        check("t3_crst_len",    64'(last_crst_len),    64'd1);
        m_mode = M_NORMAL;
        set_req(3, 64'h0000_FFFF_0000_FFFF, 64'h0123_4567_89AB_CDEF, 1'b1);
        push_exp(3, core_fn(64'h0000_FFFF_0000_FFFF, 64'h0123_4567_89AB_CDEF, 1'b1), 2'b00);
        req_valid = 4'b1000;
        @(posedge clk);
        #1;
        req_valid = '0;
        drain("t3b");

        // timeout on requester 0: core never answers
        m_mode = M_HANG;
        c0 = crst_pulses;
        set_req(0, 64'h5555_AAAA_5555_AAAA, 64'h0, 1'b0);
        push_exp(0, 64'd0, 2'b10);
        req_valid = 4'b0001;
        @(posedge clk);
        #1;
        req_valid = '0;
        drain("t4");
        check("t4_start_len",   64'(last_start_len),   64'(TIMEOUT + 1));
        check("t4_crst_pulses", 64'(crst_pulses - c0), 64'd1);
        check("t4_crst_len",    64'(last_crst_len),    64'd1);

        // response backpressure on requester 2, competitors waiting
        m_mode = M_NORMAL;
        rsp_ready = 1'b0;
        set_req(2, 64'h1357_9BDF_2468_ACE0, 64'hFEDC_BA98_7654_3210, 1'b1);
        exp_d = core_fn(64'h1357_9BDF_2468_ACE0, 64'hFEDC_BA98_7654_3210, 1'b1);
        push_exp(2, exp_d, 2'b00);
        req_valid = 4'b0100;
        @(posedge clk);
        #1;
        req_valid = '0;
        n = 0;
        while (!rsp_valid && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("t5_rsp_seen", 64'(rsp_valid), 64'd1);
        set_req(1, 64'h1, 64'h2, 1'b0);
        set_req(3, 64'h7777_0000_1234_0000, 64'h0000_8888_0000_9999, 1'b0);
        req_valid = 4'b1010;
        for (int c = 0; c < 10; c++) begin
            #1;
            check("t5_hold_valid",  64'(rsp_valid),  64'd1);
            check("t5_hold_id",     64'(rsp_id),     64'd2);
            check("t5_hold_data",   rsp_data,        exp_d);
            check("t5_hold_status", 64'(rsp_status), 64'd0);
            check("t5_hold_ready",  64'(req_ready),  64'd0);
            @(posedge clk);
            #1;
        end
        push_exp(3, core_fn(64'h7777_0000_1234_0000, 64'h0000_8888_0000_9999, 1'b0), 2'b00);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("t5_next_grant", 64'(req_ready), 64'h8);
        @(posedge clk);
        #1;
        req_valid = '0;
        drain("t5");

        // reset at RUN cycle 40 of a job on requester 1
        set_req(1, 64'hCAFE_F00D_0000_0001, 64'h0, 1'b0);
        req_valid = 4'b0010;
        @(posedge clk);
        #1;
        req_valid = '0;
        n = 0;
        while (!core_start && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("t6_start_seen", 64'(core_start), 64'd1);
        repeat (39) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("t6_busy",       64'(busy),       64'd0);
        check("t6_core_start", 64'(core_start), 64'd0);
        check("t6_rsp_valid",  64'(rsp_valid),  64'd0);
        set_req(0, 64'h0BAD_0000_0000_0000, 64'h0000_0000_0000_00FF, 1'b0);
        set_req(2, 64'h2222, 64'h3333, 1'b1);
        push_exp(0, core_fn(64'h0BAD_0000_0000_0000, 64'h0000_0000_0000_00FF, 1'b0), 2'b00);
        req_valid = 4'b0101;
        #1;
        check("t6_grant_req0", 64'(req_ready), 64'h1);
        @(posedge clk);
        #1;
        req_valid = '0;
        drain("t6");
        check("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
